// File: rtl/alu_pkg.sv
// Shared op codes and FSM encoding for the execute-stage ALU, its control unit and benches.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1101;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: WIDTH steps, low WIDTH bits of the product.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH-1:0] step_acc;

  // Accumulator value after the current step; on the last step this is the product.
  assign step_acc  = mplier[0] ? (acc + mcand) : acc;
  assign product_c = step_acc;
  assign done_c    = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes; single-cycle logic/arith ops plus sequential MUL.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  state_t           state, state_next;
  logic [WIDTH-1:0] sum, diff;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c, alu_ill_c;
  logic [WIDTH-1:0] result_d;
  logic             zero_d, overflow_d, illegal_d;
  logic             mul_start, mul_done_c;
  logic [WIDTH-1:0] mul_prod_c;

  assign sum     = src_a + src_b;
  assign diff    = src_a - src_b;
  assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1]  != src_a[WIDTH-1]);
  assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);

  // Single-cycle datapath; SLT uses the sign of A-B corrected by its overflow.
  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    alu_ill_c = 1'b0;
    case (alu_op)
      ALU_AND: alu_res_c = src_a & src_b;
      ALU_OR:  alu_res_c = src_a | src_b;
      ALU_NOR: alu_res_c = ~(src_a | src_b);
      ALU_ADD: begin alu_res_c = sum;  alu_ovf_c = add_ovf; end
      ALU_SUB: begin alu_res_c = diff; alu_ovf_c = sub_ovf; end
      ALU_SLT: alu_res_c = WIDTH'(diff[WIDTH-1] ^ sub_ovf);
      default: alu_ill_c = 1'b1;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .a         (src_a),
    .b         (src_b),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and next values of the registered result fields.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mul_start  = 1'b0;
    result_d   = result;
    zero_d     = zero;
    overflow_d = overflow;
    illegal_d  = illegal;
    case (state)
      IDLE: in_ready = 1'b1;
      MUL: begin
        if (mul_done_c) begin
          result_d   = mul_prod_c;
          zero_d     = (mul_prod_c == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          state_next = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (in_valid && in_ready) begin
      if (alu_op == ALU_MUL) begin
        mul_start  = 1'b1;
        state_next = MUL;
      end else begin
        result_d   = alu_res_c;
        zero_d     = (alu_res_c == '0);
        overflow_d = alu_ovf_c;
        illegal_d  = alu_ill_c;
        state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      result   <= result_d;
      zero     <= zero_d;
      overflow <= overflow_d;
      illegal  <= illegal_d;
    end
  end

  assign out_valid = (state == DONE);

endmodule
